// File: rtl/mont_seq_ctrl.sv
// mont_seq_ctrl
//   Sequencer for the carry-save Montgomery multiplier adder datapath.
//   One operation: clear the datapath, run the radix-2^DIGIT multiply loop
//   (one A digit per cycle), run one NCHUNK-step carry-propagate addition,
//   then repeat NCHUNK-step conditional-subtraction passes until the datapath
//   reports sub_done or MAX_SUB passes have elapsed (sticky error).
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; all datapath controls at rest
//   CLEAR | one cycle with dp_resetn low
//   MUL   | multiply loop, c_doubleshift high, b_sel = current A digit
//   ADD   | carry-propagate addition, step_idx 0..NCHUNK-1
//   SUB   | subtraction passes, subtract high, step_idx 0..NCHUNK-1
//   DONE  | one-cycle done pulse; busy drops at the following edge
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   start, a_in                 operation request and multiplier operand
//   c_zero..c_three             quotient-digit bits from the datapath
//   sub_done                    datapath subtraction-finished flag
//   dp_resetn                   active-low datapath clear
//   c_doubleshift, subtract     carry-save shift enable / subtract select
//   step_idx                    chunk/step index to the datapath
//   b_sel, m_sel                B-multiple and M-multiple gate vectors
//   busy, done, error           status (error is sticky until next start)

module mont_seq_ctrl #(
    parameter int A_WIDTH = 512,
    parameter int DIGIT   = 4,
    parameter int NCHUNK  = 6,
    parameter int MAX_SUB = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [A_WIDTH-1:0] a_in,
    input  logic               c_zero,
    input  logic               c_one,
    input  logic               c_two,
    input  logic               c_three,
    input  logic               sub_done,
    output logic               dp_resetn,
    output logic               c_doubleshift,
    output logic               subtract,
    output logic [3:0]         step_idx,
    output logic [3:0]         b_sel,
    output logic [3:0]         m_sel,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int NITER = A_WIDTH / DIGIT;
    localparam int ITW   = (NITER > 1) ? $clog2(NITER) : 1;
    localparam int PW    = (MAX_SUB > 1) ? $clog2(MAX_SUB) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        MUL   = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t             state;
    logic [A_WIDTH-1:0] aSh;
    logic [ITW-1:0]     iter;
    logic [3:0]         idx;
    logic [PW-1:0]      pass;

    // Quotient digit comes straight from the datapath in the same cycle.
    assign m_sel = (state == MUL) ? {c_three, c_two, c_one, c_zero} : 4'b0000;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            aSh           <= '0;
            iter          <= '0;
            idx           <= '0;
            pass          <= '0;
            dp_resetn     <= 1'b1;
            c_doubleshift <= 1'b0;
            subtract      <= 1'b0;
            step_idx      <= 4'd0;
            b_sel         <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CLEAR;
                        aSh       <= a_in;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        dp_resetn <= 1'b0;
                    end
                end

                CLEAR: begin
                    // b_sel is registered, so the shift register runs one
                    // digit ahead of what the datapath currently sees.
                    state         <= MUL;
                    dp_resetn     <= 1'b1;
                    c_doubleshift <= 1'b1;
                    b_sel         <= aSh[3:0];
                    aSh           <= aSh >> DIGIT;
                    iter          <= '0;
                end

                MUL: begin
                    if (iter == ITW'(NITER - 1)) begin
                        state         <= ADD;
                        c_doubleshift <= 1'b0;
                        b_sel         <= 4'd0;
                        idx           <= 4'd0;
                        step_idx      <= 4'd0;
                    end else begin
                        iter  <= iter + 1'b1;
                        b_sel <= aSh[3:0];
                        aSh   <= aSh >> DIGIT;
                    end
                end

                ADD: begin
                    if (idx == 4'(NCHUNK - 1)) begin
                        state    <= SUB;
                        idx      <= 4'd0;
                        pass     <= '0;
                        subtract <= 1'b1;
                        step_idx <= 4'd0;
                    end else begin
                        idx      <= idx + 4'd1;
                        step_idx <= idx + 4'd1;
                    end
                end

                SUB: begin
                    if (idx == 4'(NCHUNK - 1)) begin
                        if (sub_done || (pass == PW'(MAX_SUB - 1))) begin
                            state    <= DONE;
                            subtract <= 1'b0;
                            step_idx <= 4'd0;
                            done     <= 1'b1;
                            if (!sub_done) begin
                                error <= 1'b1;
                            end
                        end else begin
                            pass     <= pass + 1'b1;
                            idx      <= 4'd0;
                            step_idx <= 4'd0;
                        end
                    end else begin
                        idx      <= idx + 4'd1;
                        step_idx <= idx + 4'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_seq_ctrl.sv
module tb_mont_seq_ctrl;

    localparam int A_WIDTH = 512;
    localparam int DIGIT   = 4;
    localparam int NCHUNK  = 6;
    localparam int MAX_SUB = 4;
    localparam int NITER   = A_WIDTH / DIGIT;

    logic               clk = 1'b0;
    logic               resetn;
    logic               start;
    logic [A_WIDTH-1:0] a_in;
    logic               c_zero, c_one, c_two, c_three;
    logic               sub_done;
    logic               dp_resetn, c_doubleshift, subtract, busy, done, error;
    logic [3:0]         step_idx, b_sel, m_sel;

    int checks = 0;
    int errors = 0;

    mont_seq_ctrl #(
        .A_WIDTH(A_WIDTH), .DIGIT(DIGIT), .NCHUNK(NCHUNK), .MAX_SUB(MAX_SUB)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .a_in(a_in),
        .c_zero(c_zero), .c_one(c_one), .c_two(c_two), .c_three(c_three),
        .sub_done(sub_done), .dp_resetn(dp_resetn), .c_doubleshift(c_doubleshift),
        .subtract(subtract), .step_idx(step_idx), .b_sel(b_sel), .m_sel(m_sel),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic expErr);
        chk({tag, ".dp_resetn"}, 32'(dp_resetn), 1);
        chk({tag, ".cds"}, 32'(c_doubleshift), 0);
        chk({tag, ".subtract"}, 32'(subtract), 0);
        chk({tag, ".step_idx"}, 32'(step_idx), 0);
        chk({tag, ".b_sel"}, 32'(b_sel), 0);
        chk({tag, ".m_sel"}, 32'(m_sel), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".error"}, 32'(error), 32'(expErr));
    endtask

    task automatic set_c(input logic [3:0] c);
        {c_three, c_two, c_one, c_zero} = c;
    endtask

    // One full operation. pOk = pass (1-based) on which sub_done is reported,
    // 0 = never. Cycle n=1 is the cycle right after the edge that accepts start.
    task automatic run_op(input logic [A_WIDTH-1:0] a, input int pOk, input bit hold);
        int passes, total, m;
        logic [3:0] c, eB, eM, eStep;
        logic eDp, eCds, eSub, eDone, eErr, sd;
        passes = (pOk == 0) ? MAX_SUB : pOk;
        total  = 2 + NITER + NCHUNK * (1 + passes);
        a_in     = a;
        start    = 1'b1;
        sub_done = 1'b0;
        @(posedge clk); #1;
        start = hold;
        for (int n = 1; n <= total; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            c = 4'($urandom_range(0, 15));
            if (n == 2 || n == NITER + 2) c = 4'b1011;
            eDp = 1'b1; eCds = 1'b0; eSub = 1'b0; eStep = 4'd0; eB = 4'd0; eM = 4'd0;
            eDone = 1'b0; eErr = 1'b0; sd = 1'($urandom_range(0, 1));
            if (n == 1) begin
                eDp = 1'b0;
            end else if (n <= NITER + 1) begin
                eCds = 1'b1;
                eB   = 4'((a >> (DIGIT * (n - 2))) & 'hF);
                eM   = c;
            end else if (n <= NITER + 1 + NCHUNK) begin
                eStep = 4'(n - (NITER + 2));
            end else if (n < total) begin
                m     = n - (NITER + 2 + NCHUNK);
                eSub  = 1'b1;
                eStep = 4'(m % NCHUNK);
                if (m % NCHUNK == NCHUNK - 1) sd = ((m / NCHUNK) + 1 == pOk);
            end else begin
                eDone = 1'b1;
                eErr  = (pOk == 0);
            end
            set_c(c);
            sub_done = sd;
            if (!hold) start = (n < total - 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
            #1;
            chk($sformatf("n%0d.dp_resetn", n), 32'(dp_resetn), 32'(eDp));
            chk($sformatf("n%0d.cds", n), 32'(c_doubleshift), 32'(eCds));
            chk($sformatf("n%0d.subtract", n), 32'(subtract), 32'(eSub));
            chk($sformatf("n%0d.step_idx", n), 32'(step_idx), 32'(eStep));
            chk($sformatf("n%0d.b_sel", n), 32'(b_sel), 32'(eB));
            chk($sformatf("n%0d.m_sel", n), 32'(m_sel), 32'(eM));
            chk($sformatf("n%0d.busy", n), 32'(busy), 1);
            chk($sformatf("n%0d.done", n), 32'(done), 32'(eDone));
            chk($sformatf("n%0d.error", n), 32'(error), 32'(eErr));
        end
        set_c(4'b0);
        sub_done = 1'b0;
        @(posedge clk); #1;
        chk_idle("post_done", pOk == 0);
    endtask

    function automatic logic [A_WIDTH-1:0] rand_a();
        logic [A_WIDTH-1:0] v;
        for (int i = 0; i < A_WIDTH / 32; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    initial begin
        resetn = 1'b0; start = 1'b0; a_in = '0; sub_done = 1'b0;
        set_c(4'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset", 1'b0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk_idle("idle", 1'b0);

        // Directed: small operand, single subtract pass
        run_op(A_WIDTH'(32'h0000_00A5), 1, 1'b0);
        // Three subtract passes
        run_op(rand_a(), 3, 1'b0);
        // Never converges -> abort with sticky error
        run_op(rand_a(), 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_idle("error_sticky", 1'b1);

        // Reset in the middle of the multiply loop
        a_in  = rand_a();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (51) @(posedge clk);
        #1;
        chk("mid_mul.cds", 32'(c_doubleshift), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        chk_idle("mid_mul_reset", 1'b0);
        @(posedge clk); #1;

        // Fresh full run after the reset
        run_op(rand_a(), 1, 1'b0);

        // start held high: back-to-back runs with one idle cycle between
        run_op(rand_a(), 2, 1'b1);
        run_op(rand_a(), 1, 1'b1);
        start = 1'b0;
        @(posedge clk); #1;
        chk_idle("after_hold", 1'b0);

        // Random operands and pass counts
        for (int r = 0; r < 4; r++) begin
            run_op(rand_a(), $urandom_range(0, MAX_SUB), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
